// File: rtl/modport_reg_file_if.sv
// ============================================================================
// Module   : modport_reg_file_if
// Brief    : Write/read bus between a master and the modport_reg_file slave.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface modport_reg_file_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;

   modport master (
      output write,
      output address,
      output data_in,
      input  data_out
   );

   modport slave (
      input  write,
      input  address,
      input  data_in,
      output data_out
   );
endinterface

`default_nettype wire

// File: rtl/modport_reg_file.sv
// ============================================================================
// Module   : modport_reg_file
// Brief    : 2**ADDR_W x DATA_W register file, registered read, sync reset.
//            Define MODPORT_REG_FILE_BYPASS_EN for write-first read-during-write.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module modport_reg_file #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  wire                     clk,
   input  wire                     rst,
   modport_reg_file_if.slave       bus
);

   localparam int c_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [c_DEPTH];
   logic [DATA_W-1:0] r_data_out;
   logic [DATA_W-1:0] w_rd_data;

`ifdef MODPORT_REG_FILE_BYPASS_EN
   // Same-cycle write wins: the read port sees the incoming data.
   assign w_rd_data = bus.write ? bus.data_in : r_mem[bus.address];
`else
   assign w_rd_data = r_mem[bus.address];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_data_out <= '0;
      end else begin
         if (bus.write) begin
            r_mem[bus.address] <= bus.data_in;
         end
         r_data_out <= w_rd_data;
      end
   end

   assign bus.data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_modport_reg_file.sv
// ============================================================================
// Module   : tb_modport_reg_file
// Brief    : Scoreboard bench for modport_reg_file.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_modport_reg_file;

   localparam int c_ADDR_W = 8;
   localparam int c_DATA_W = 16;

`ifdef MODPORT_REG_FILE_BYPASS_EN
   localparam bit c_BYPASS = 1'b1;
`else
   localparam bit c_BYPASS = 1'b0;
`endif

   typedef struct {
      string             tag;
      logic [c_DATA_W-1:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   exp_t r_sb [$];

   modport_reg_file_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

   modport_reg_file #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [c_DATA_W-1:0] got,
                        input logic [c_DATA_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, push expectation, compare after the edge.
   task automatic step(input logic r, input logic w, input logic [c_ADDR_W-1:0] a,
                       input logic [c_DATA_W-1:0] d, input bit chk,
                       input logic [c_DATA_W-1:0] exp, input string tag);
      exp_t e;
      @(negedge clk);
      rst         = r;
      bus.write   = w;
      bus.address = a;
      bus.data_in = d;
      if (chk) begin
         e.tag = tag;
         e.exp = exp;
         r_sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (chk) begin
         if (r_sb.size() == 0) begin
            check("sb_empty", 16'hDEAD, 16'h0000);
         end else begin
            e = r_sb.pop_front();
            check(e.tag, bus.data_out, e.exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [c_DATA_W-1:0] v;
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      bus.write   = 1'b0;
      bus.address = '0;
      bus.data_in = '0;

      // Initial reset and reset-state read
      step(1, 0, 8'h00, 16'h0000, 1, 16'h0000, "rst_init");
      step(0, 0, 8'h10, 16'h0000, 1, 16'h0000, "unwritten_10");

      // Reset clears contents and output
      step(0, 1, 8'h10, 16'h1234, 0, 16'h0000, "");
      step(0, 0, 8'h10, 16'h0000, 1, 16'h1234, "pre_rst_10");
      step(1, 0, 8'h10, 16'h0000, 1, 16'h0000, "rst_cyc1");
      step(1, 0, 8'h10, 16'h0000, 1, 16'h0000, "rst_cyc2");
      step(0, 0, 8'h10, 16'h0000, 1, 16'h0000, "post_rst_10");

      // Basic write then read, including top address
      step(0, 1, 8'h00, 16'hBEEF, 0, 16'h0000, "");
      step(0, 1, 8'hFF, 16'hA5A5, 0, 16'h0000, "");
      step(0, 0, 8'h00, 16'h0000, 1, 16'hBEEF, "rd_00");
      step(0, 0, 8'hFF, 16'h0000, 1, 16'hA5A5, "rd_ff");
      step(0, 0, 8'h00, 16'h0000, 1, 16'hBEEF, "rd_00_again");

      // Read-during-write on the same address
      step(0, 1, 8'h20, 16'h1111, 0, 16'h0000, "");
      step(0, 1, 8'h20, 16'h2222, 1, c_BYPASS ? 16'h2222 : 16'h1111, "rdw_same");
      step(0, 0, 8'h20, 16'h0000, 1, 16'h2222, "rdw_next");

      // Back-to-back writes keep the last value
      step(0, 1, 8'h21, 16'h0AAA, 0, 16'h0000, "");
      step(0, 1, 8'h21, 16'h0BBB, 0, 16'h0000, "");
      step(0, 0, 8'h21, 16'h0000, 1, 16'h0BBB, "b2b_last");

      // Reset has priority over a coincident write
      step(1, 1, 8'h30, 16'h5555, 1, 16'h0000, "rst_wr_out");
      step(0, 0, 8'h30, 16'h0000, 1, 16'h0000, "rst_wr_30");
      step(0, 0, 8'h00, 16'h0000, 1, 16'h0000, "rst_cleared_00");

      // Walking ones at 0x00..0x0F, then full sweep
      for (int a = 0; a < 16; a++) begin
         step(0, 1, a[7:0], 16'h0001 << a, 0, 16'h0000, "");
      end
      for (int a = 0; a < 256; a++) begin
         v = (a < 16) ? (16'h0001 << a) : 16'h0000;
         step(0, 0, a[7:0], 16'h0000, 1, v, $sformatf("iso_%02h", a));
      end

      // Hold: write strobe low, data_in toggling
      step(0, 1, 8'h40, 16'h0F0F, 0, 16'h0000, "");
      for (int i = 0; i < 10; i++) begin
         v = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
         step(0, 0, 8'h40, v ^ 16'h00FF * i[15:0], 1, 16'h0F0F, $sformatf("hold_%0d", i));
      end
      step(0, 0, 8'h41, 16'h0000, 1, 16'h0000, "hold_neighbor");
      step(0, 0, 8'h40, 16'h0000, 1, 16'h0F0F, "hold_final");

      if (r_sb.size() != 0) begin
         check("sb_leftover", 16'(r_sb.size()), 16'h0000);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
